// File: rtl/controle_pilha_pkg.sv
// Shared types for the stack calculator control unit: FSM state encoding and error codes.
package controle_pilha_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        EMPILHA_DADO,
        INICIA_ULA,
        AGUARDA_ULA,
        DESEMPILHA,
        EMPILHA_RES,
        ERRO
    } estado_t;

    localparam logic [1:0] ERRO_NENHUM  = 2'd0;
    localparam logic [1:0] ERRO_CHEIA   = 2'd1;
    localparam logic [1:0] ERRO_VAZIA   = 2'd2;
    localparam logic [1:0] ERRO_TIMEOUT = 2'd3;

endpackage

// File: rtl/controle_pilha_param_detector_borda.sv
// Rising-edge detector for an already-debounced synchronous key level.
module detector_borda (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sinal_i,
    output logic sobe_o
);

    logic sinal_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sinal_q <= 1'b0;
        end else begin
            sinal_q <= sinal_i;
        end
    end

    assign sobe_o = sinal_i & ~sinal_q;

endmodule

// File: rtl/controle_pilha_param.sv
// Stack calculator control unit: pushes switch data, runs ALU ops with a timeout,
// pops the consumed operands and pushes the result, reporting overflow/underflow/timeout.
module controle_pilha_param
    import controle_pilha_pkg::*;
#(
    parameter int                    DATA_W       = 8,
    parameter int                    OP_W         = 3,
    parameter int                    PROFUNDIDADE = 16,
    parameter logic [2**OP_W-1:0]    UNARIA_MASK  = 8'b1100_0000,
    parameter int                    TIMEOUT      = 255
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 KEY0,
    input  logic                                 KEY1,
    input  logic [DATA_W-1:0]                    SW,
    input  logic                                 ula_pronto,
    input  logic [$clog2(PROFUNDIDADE+1)-1:0]    pilha_nivel,
    output logic                                 pilha_empilha,
    output logic                                 pilha_desempilha,
    output logic                                 pilha_sel_sw,
    output logic                                 empilha_resultado,
    output logic                                 ula_inicia,
    output logic [OP_W-1:0]                      ula_op_code,
    output logic                                 ocupado,
    output logic [1:0]                           erro
);

    localparam int NIVEL_W = $clog2(PROFUNDIDADE+1);
    localparam int CNT_W   = $clog2(TIMEOUT+1);

    estado_t            estado_q, estado_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [1:0]         n_q, n_d;
    logic [CNT_W-1:0]   tempo_q, tempo_d;
    logic [1:0]         pops_q, pops_d;
    logic [1:0]         erro_q, erro_d;

    logic               sobe0, sobe1;
    logic [OP_W-1:0]    opSw;
    logic [1:0]         nSw;
    logic               unusedSw;

    detector_borda uBorda0 (
        .clk_i   (Clk),
        .reset_i (Reset),
        .sinal_i (KEY0),
        .sobe_o  (sobe0)
    );

    detector_borda uBorda1 (
        .clk_i   (Clk),
        .reset_i (Reset),
        .sinal_i (KEY1),
        .sobe_o  (sobe1)
    );

    // Only the low bits select the op; the rest of SW is push data for the stack.
    assign opSw     = SW[OP_W-1:0];
    assign nSw      = UNARIA_MASK[opSw] ? 2'd1 : 2'd2;
    assign unusedSw = ^SW[DATA_W-1:OP_W];

    always_comb begin
        estado_d = estado_q;
        op_d     = op_q;
        n_d      = n_q;
        tempo_d  = tempo_q;
        pops_d   = pops_q;
        erro_d   = erro_q;
        case (estado_q)
            OCIOSO: begin
                if (sobe0) begin
                    if (pilha_nivel < NIVEL_W'(PROFUNDIDADE)) begin
                        estado_d = EMPILHA_DADO;
                    end else begin
                        estado_d = ERRO;
                        erro_d   = ERRO_CHEIA;
                    end
                end else if (sobe1) begin
                    op_d = opSw;
                    n_d  = nSw;
                    if (pilha_nivel >= NIVEL_W'(nSw)) begin
                        estado_d = INICIA_ULA;
                    end else begin
                        estado_d = ERRO;
                        erro_d   = ERRO_VAZIA;
                    end
                end
            end
            EMPILHA_DADO: estado_d = OCIOSO;
            INICIA_ULA: begin
                tempo_d  = '0;
                estado_d = AGUARDA_ULA;
            end
            AGUARDA_ULA: begin
                // A completion arriving in the last allowed cycle still wins over the timeout.
                if (ula_pronto) begin
                    pops_d   = n_q;
                    estado_d = DESEMPILHA;
                end else begin
                    tempo_d = tempo_q + CNT_W'(1);
                    if (tempo_d == CNT_W'(TIMEOUT)) begin
                        estado_d = ERRO;
                        erro_d   = ERRO_TIMEOUT;
                    end
                end
            end
            DESEMPILHA: begin
                pops_d = pops_q - 2'd1;
                if (pops_q == 2'd1) begin
                    estado_d = EMPILHA_RES;
                end
            end
            EMPILHA_RES: estado_d = OCIOSO;
            ERRO: begin
                if (sobe0 || sobe1) begin
                    estado_d = OCIOSO;
                    erro_d   = ERRO_NENHUM;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado_q <= OCIOSO;
            op_q     <= '0;
            n_q      <= 2'd2;
            tempo_q  <= '0;
            pops_q   <= '0;
            erro_q   <= ERRO_NENHUM;
        end else begin
            estado_q <= estado_d;
            op_q     <= op_d;
            n_q      <= n_d;
            tempo_q  <= tempo_d;
            pops_q   <= pops_d;
            erro_q   <= erro_d;
        end
    end

    // Moore decode: every output depends only on registered state.
    always_comb begin
        pilha_empilha     = 1'b0;
        pilha_desempilha  = 1'b0;
        pilha_sel_sw      = 1'b0;
        empilha_resultado = 1'b0;
        ula_inicia        = 1'b0;
        ula_op_code       = '0;
        ocupado           = (estado_q != OCIOSO) && (estado_q != ERRO);
        erro              = erro_q;
        case (estado_q)
            EMPILHA_DADO: begin
                pilha_empilha = 1'b1;
                pilha_sel_sw  = 1'b1;
            end
            INICIA_ULA: begin
                ula_inicia  = 1'b1;
                ula_op_code = op_q;
            end
            AGUARDA_ULA: ula_op_code = op_q;
            DESEMPILHA:  pilha_desempilha = 1'b1;
            EMPILHA_RES: begin
                pilha_empilha     = 1'b1;
                empilha_resultado = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controle_pilha_param.sv
// Bench for controle_pilha_param: directed and random key transactions checked against a
// transaction-level schedule of expected per-cycle outputs.
module tb_controle_pilha_param;

    localparam int                PROF    = 16;
    localparam int                TMO     = 4;
    localparam logic [7:0]        MASK    = 8'b1100_0000;

    // {empilha, desempilha, sel_sw, resultado, inicia, op[2:0], ocupado, erro[1:0]}
    typedef logic [10:0] vec_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        KEY0, KEY1;
    logic [7:0]  SW;
    logic        ula_pronto;
    logic [4:0]  pilha_nivel;
    logic        pilha_empilha, pilha_desempilha, pilha_sel_sw, empilha_resultado;
    logic        ula_inicia, ocupado;
    logic [2:0]  ula_op_code;
    logic [1:0]  erro;

    int          vectors = 0;
    int          miscompares = 0;
    vec_t        expQ[$];
    vec_t        lastVec = '0;
    logic [1:0]  modelErro = 2'd0;

    controle_pilha_param #(
        .DATA_W       (8),
        .OP_W         (3),
        .PROFUNDIDADE (PROF),
        .UNARIA_MASK  (MASK),
        .TIMEOUT      (TMO)
    ) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .KEY0              (KEY0),
        .KEY1              (KEY1),
        .SW                (SW),
        .ula_pronto        (ula_pronto),
        .pilha_nivel       (pilha_nivel),
        .pilha_empilha     (pilha_empilha),
        .pilha_desempilha  (pilha_desempilha),
        .pilha_sel_sw      (pilha_sel_sw),
        .empilha_resultado (empilha_resultado),
        .ula_inicia        (ula_inicia),
        .ula_op_code       (ula_op_code),
        .ocupado           (ocupado),
        .erro              (erro)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input bit emp, input bit des, input bit sel, input bit res,
                                input bit ini, input logic [2:0] op, input bit ocu,
                                input logic [1:0] err);
        return {emp, des, sel, res, ini, op, ocu, err};
    endfunction

    function automatic vec_t idleVec();
        return mk(0, 0, 0, 0, 0, 3'd0, 0, modelErro);
    endfunction

    function automatic vec_t observed();
        return {pilha_empilha, pilha_desempilha, pilha_sel_sw, empilha_resultado,
                ula_inicia, ula_op_code, ocupado, erro};
    endfunction

    // Busy with no strobe at all means the unit is waiting for the ALU.
    function automatic bit isWait(input vec_t v);
        return v[2] && (v[10:6] == 5'b0);
    endfunction

    task automatic checkOutput(input string tag);
        vec_t expV;
        vec_t obsV;
        @(posedge Clk);
        #1;
        expV = (expQ.size() > 0) ? expQ.pop_front() : idleVec();
        obsV = observed();
        vectors++;
        assert (obsV === expV) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obsV, expV);
        end
        lastVec = expV;
    endtask

    // Drives one key transaction; the expected output schedule is built from the
    // operational rules (operand count, timeout window) rather than from FSM states.
    task automatic applyStimulus(input bit k0, input bit k1, input int level,
                                 input logic [7:0] sw, input int k, input bit noise,
                                 input int hold, input string tag);
        int          prontoTick = -1;
        int          i = 0;
        int          n;
        int          waitCycles;
        logic [2:0]  op;
        pilha_nivel = 5'(level);
        SW          = sw;
        KEY0        = k0;
        KEY1        = k1;
        if (modelErro != 2'd0) begin
            modelErro = 2'd0;
            expQ.push_back(idleVec());
        end else if (k0) begin
            if (level < PROF) begin
                expQ.push_back(mk(1, 0, 1, 0, 0, 3'd0, 1, 2'd0));
            end else begin
                modelErro = 2'd1;
            end
            expQ.push_back(idleVec());
        end else begin
            op = sw[2:0];
            n  = MASK[op] ? 1 : 2;
            if (level < n) begin
                modelErro = 2'd2;
                expQ.push_back(idleVec());
            end else begin
                prontoTick = 2 + k;
                waitCycles = (k < TMO) ? k + 1 : TMO;
                expQ.push_back(mk(0, 0, 0, 0, 1, op, 1, 2'd0));
                repeat (waitCycles) expQ.push_back(mk(0, 0, 0, 0, 0, op, 1, 2'd0));
                if (k < TMO) begin
                    repeat (n) expQ.push_back(mk(0, 1, 0, 0, 0, 3'd0, 1, 2'd0));
                    expQ.push_back(mk(1, 0, 0, 1, 0, 3'd0, 1, 2'd0));
                end else begin
                    modelErro = 2'd3;
                end
                expQ.push_back(idleVec());
            end
        end
        while (expQ.size() > 0) begin
            if (i > 0 && noise && lastVec[2]) begin
                KEY0 = 1'($urandom_range(0, 1));
                KEY1 = 1'($urandom_range(0, 1));
            end
            if (i == prontoTick)    ula_pronto = 1'b1;
            else if (isWait(lastVec)) ula_pronto = 1'b0;
            else                    ula_pronto = 1'($urandom_range(0, 1));
            checkOutput(tag);
            i++;
        end
        for (int h = 0; h < hold; h++) checkOutput({tag, "_hold"});
        KEY0       = 1'b0;
        KEY1       = 1'b0;
        ula_pronto = 1'($urandom_range(0, 1));
        checkOutput({tag, "_release"});
    endtask

    initial begin
        int sel;
        $display("[TB] controle_pilha_param bench starting");
        Reset       = 1'b1;
        KEY0        = 1'b0;
        KEY1        = 1'b0;
        SW          = 8'h00;
        ula_pronto  = 1'b0;
        pilha_nivel = 5'd0;
        checkOutput("reset");
        checkOutput("reset");
        Reset = 1'b0;
        checkOutput("post_reset");

        applyStimulus(1, 0, 0,  8'h2A, 0,  0, 5, "push_held");
        applyStimulus(0, 1, 2,  8'h01, 3,  0, 0, "binop_k3");
        applyStimulus(0, 1, 1,  8'h06, 0,  0, 0, "unary");
        applyStimulus(0, 1, 1,  8'h01, 0,  0, 2, "underflow");
        applyStimulus(0, 1, 1,  8'h01, 0,  0, 0, "clear_underflow");
        applyStimulus(1, 0, 16, 8'h55, 0,  0, 1, "overflow");
        applyStimulus(0, 1, 16, 8'h01, 0,  0, 1, "clear_overflow");
        applyStimulus(0, 1, 2,  8'h02, 10, 0, 2, "timeout");
        applyStimulus(1, 0, 3,  8'h00, 0,  0, 0, "clear_timeout");
        applyStimulus(0, 1, 5,  8'h07, 4,  0, 0, "unary_timeout_edge");
        applyStimulus(1, 0, 3,  8'h00, 0,  0, 0, "clear_timeout2");
        applyStimulus(1, 1, 3,  8'h01, 0,  0, 0, "both_keys");
        applyStimulus(1, 1, 16, 8'h01, 0,  0, 0, "both_keys_full");
        applyStimulus(0, 1, 0,  8'h00, 0,  0, 0, "clear_full");

        // Reset while waiting for the ALU must abort with no pops or push afterwards.
        pilha_nivel = 5'd2;
        SW          = 8'h01;
        ula_pronto  = 1'b0;
        KEY1        = 1'b1;
        expQ.push_back(mk(0, 0, 0, 0, 1, 3'd1, 1, 2'd0));
        expQ.push_back(mk(0, 0, 0, 0, 0, 3'd1, 1, 2'd0));
        checkOutput("rst_mid_start");
        checkOutput("rst_mid_wait");
        Reset = 1'b1;
        KEY1  = 1'b0;
        modelErro = 2'd0;
        checkOutput("rst_mid_abort");
        Reset      = 1'b0;
        ula_pronto = 1'b1;
        repeat (4) checkOutput("rst_after");
        ula_pronto = 1'b0;

        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(0, 2));
            applyStimulus(sel != 1, sel != 0, int'($urandom_range(0, PROF)),
                          8'($urandom), int'($urandom_range(0, 6)), 1,
                          int'($urandom_range(0, 2)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/controle_pilha_param.md
# controle_pilha_param

Parametrised control unit for the stack calculator: sequences data pushes from the switches, launches ALU operations, waits for completion with a timeout, and pops the consumed operands before pushing the result. It sits between the user inputs (KEY0/KEY1/SW), the stack, and the ALU. Compared with the fixed 3-bit, single-path unit, it adds:
- width and depth parameters,
- rising-edge key detection,
- operand-count-aware popping,
- overflow, underflow and timeout error reporting.

## Interface
- DATA_W, 8, width of SW data bus
- OP_W, 3, width of ALU op code
- PROFUNDIDADE, 16, stack depth in words
- UNARIA_MASK, 8'b1100_0000, 2**OP_W bits; bit k=1 means op k uses 1 operand, else 2
- TIMEOUT, 255, max cycles waiting for ula_pronto (≥1)
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- KEY0  in  1  push request (debounced, synchronous level)
- KEY1  in  1  execute request (debounced, synchronous level)
- SW  in  DATA_W  data for push; SW[OP_W-1:0] is the op code on execute
- ula_pronto  in  1  ALU done
- pilha_nivel  in  $clog2(PROFUNDIDADE+1)  current stack occupancy
- pilha_empilha  out  1  push strobe
- pilha_desempilha  out  1  pop strobe
- pilha_sel_sw  out  1  push source = SW
- empilha_resultado  out  1  push source = ALU result
- ula_inicia  out  1  one-cycle ALU start pulse
- ula_op_code  out  OP_W  latched op; zero outside INICIA_ULA/AGUARDA_ULA
- ocupado  out  1  high in every state except OCIOSO and ERRO
- erro  out  2  0 none, 1 overflow, 2 underflow, 3 timeout

## Operation
- Edge detect: registers key0_q/key1_q; sobe0 = KEY0 & ~key0_q, sobe1 = KEY1 & ~key1_q. A held key acts once.
- States: OCIOSO, EMPILHA_DADO, INICIA_ULA, AGUARDA_ULA, DESEMPILHA, EMPILHA_RES, ERRO.
- OCIOSO, sobe0:
  - pilha_nivel < PROFUNDIDADE → EMPILHA_DADO.
  - Otherwise → ERRO, erro=1.
- OCIOSO, sobe1 only:
  - Latch op = SW[OP_W-1:0] and operand count n = UNARIA_MASK[op] ? 1 : 2.
  - pilha_nivel ≥ n → INICIA_ULA.
  - Otherwise → ERRO, erro=2.
- OCIOSO, sobe0 and sobe1 in the same cycle: KEY0 wins, KEY1 is ignored.
- EMPILHA_DADO: pilha_empilha=1, pilha_sel_sw=1 for one cycle → OCIOSO.
- INICIA_ULA: ula_inicia=1 for one cycle; timeout counter cleared → AGUARDA_ULA.
- AGUARDA_ULA:
  - ula_pronto=1 → DESEMPILHA with pop counter = n.
  - Otherwise the counter increments; when it reaches TIMEOUT → ERRO, erro=3.
- DESEMPILHA: pilha_desempilha=1 each cycle, counter decrements; after n cycles → EMPILHA_RES.
- EMPILHA_RES: pilha_empilha=1, empilha_resultado=1 for one cycle → OCIOSO. Space is always available because at least one word was popped.
- ERRO: erro held; all strobes 0; any sobe0 or sobe1 clears erro → OCIOSO. That key edge is not executed.
- Key edges outside OCIOSO/ERRO are ignored. The edge registers still track the keys.
- pilha_sel_sw and empilha_resultado are never high together.

## Timing
- Reset (synchronous): state=OCIOSO, key0_q=key1_q=0, counters=0, all outputs 0 at the next edge. Reset mid-operation aborts with no further strobes.
- Key edge sampled at edge t → strobe or ula_inicia is visible during cycle t+1.
- Binary op with ula_pronto sampled k cycles after entering AGUARDA_ULA:
  - ula_inicia at cycle t+1,
  - pops at t+3+k and t+4+k,
  - result push at t+5+k.
- Unary op: one fewer cycle than binary.
- Timeout: ERRO is entered exactly TIMEOUT cycles after entering AGUARDA_ULA if ula_pronto never rises. If ula_pronto rises in the timeout cycle itself, ula_pronto takes priority.
- All outputs are Moore (decoded from registered state/op), so no combinational path from inputs to outputs.

## Structure
- Package controle_pilha_pkg: state enum estado_t, error codes ERRO_NENHUM/ERRO_CHEIA/ERRO_VAZIA/ERRO_TIMEOUT.
- One natural sub-module: detector_borda (register plus rising-edge pulse), instantiated for KEY0 and KEY1.
- Timeout counter and pop counter stay inline.

## Test plan
- Reset, then KEY0 held 5 cycles with SW=8'h2A, pilha_nivel=0 → exactly one pilha_empilha+pilha_sel_sw pulse, one cycle after the rise.
- pilha_nivel=2, KEY1 rise with SW[2:0]=3'd1, ula_pronto after 3 cycles → op_code=1 during wait, 2 desempilha pulses, then empilha_resultado pulse, back to OCIOSO.
- pilha_nivel=1, SW[2:0]=3'd6 (unary) → 1 pop then push. Same level with op 1 → erro=2, no ula_inicia.
- pilha_nivel=16, KEY0 rise → erro=1, no push. Next KEY1 rise → erro=0, OCIOSO, no op started.
- TIMEOUT=4, ula_pronto held 0 → erro=3 exactly 4 cycles after entering AGUARDA_ULA; no pops.
- KEY0 and KEY1 rising together → push only. Reset asserted in AGUARDA_ULA → all outputs 0 next cycle, and no pop/push after release.
